id_ex_pipe_reg: RTL

//  Decode->Execute pipeline register of the 5-stage MIPS core. Captures the decode-stage

---
 rtl/mips_pkg.sv | 34 +++
 rtl/pipe_reg_ce_clr.sv | 23 ++
 rtl/id_ex_pipe_reg.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU operation codes, register constants and the
// execute-stage control word used by the pipeline registers.
package mips_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'h0,
      ALU_OR  = 4'h1,
      ALU_ADD = 4'h2,
      ALU_SUB = 4'h6,
      ALU_SLT = 4'h7
   } aluControl_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic       regWrite;
      logic       memtoReg;
      logic       memWrite;
      logic       aluSrc;
      logic       regDst;
      logic [3:0] aluControl;
   } ctrl_t;

   localparam int    CTRL_W      = $bits(ctrl_t);
   localparam ctrl_t BUBBLE_CTRL = '0;

   // Destination register chosen by RegDst: rd for R-type, rt otherwise.
   function automatic logic [4:0] resolveWriteReg(input logic regDst,
                                                  input logic [4:0] rt,
                                                  input logic [4:0] rd);
      return regDst ? rd : rt;
   endfunction

endpackage

// File: rtl/pipe_reg_ce_clr.sv
// Generic pipeline register with clock enable and synchronous clear
// (clear wins over enable) plus asynchronous active-low reset.
module pipe_reg_ce_clr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register: bubble insertion on flush or invalid slot,
// $zero write guard, write-register resolution and saturating stall/bubble counters.
module id_ex_pipe_reg
   import mips_pkg::*;
#(
   parameter int DW   = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StallE,
   input  logic            FlushE,
   input  logic            ValidD,
   input  logic [DW-1:0]   ImmD_32,
   input  logic [DW-1:0]   RD1D,
   input  logic [DW-1:0]   RD2D,
   input  logic [4:0]      RsD,
   input  logic [4:0]      RtD,
   input  logic [4:0]      RdD,
   input  logic [DW-1:0]   PCPlus4D,
   input  logic            RegWriteD,
   input  logic            MemtoRegD,
   input  logic            MemWriteD,
   input  logic            ALUSrcD,
   input  logic            RegDstD,
   input  logic [3:0]      ALUControlD,
   output logic [DW-1:0]   ImmE,
   output logic [DW-1:0]   RD1E,
   output logic [DW-1:0]   RD2E,
   output logic [4:0]      RsE,
   output logic [4:0]      RtE,
   output logic [4:0]      RdE,
   output logic [DW-1:0]   PCPlus4E,
   output logic            RegWriteE,
   output logic            MemtoRegE,
   output logic            MemWriteE,
   output logic            ALUSrcE,
   output logic            RegDstE,
   output logic [3:0]      ALUControlE,
   output logic [4:0]      WriteRegE,
   output logic            ValidE,
   output logic [CNTW-1:0] StallCntE,
   output logic [CNTW-1:0] BubbleCntE
);

   localparam int DATA_W = 4*DW + 4*5;

   logic [4:0]        writeRegD;
   ctrl_t             ctrlLoad;
   ctrl_t             ctrlE;
   logic [DATA_W-1:0] dataD;
   logic [DATA_W-1:0] dataE;
   logic              loadEn;
   logic              stallInc;
   logic              bubbleInc;

   assign writeRegD = resolveWriteReg(RegDstD, RtD, RdD);
   assign loadEn    = !StallE;

   // An invalid slot loads the all-zero control word so it can never write state.
   always_comb begin
      ctrlLoad = BUBBLE_CTRL;
      if (ValidD) begin
         ctrlLoad.regWrite   = RegWriteD && (writeRegD != REG_ZERO);
         ctrlLoad.memtoReg   = MemtoRegD;
         ctrlLoad.memWrite   = MemWriteD;
         ctrlLoad.aluSrc     = ALUSrcD;
         ctrlLoad.regDst     = RegDstD;
         ctrlLoad.aluControl = ALUControlD;
      end
   end

   assign dataD = {ImmD_32, RD1D, RD2D, PCPlus4D, RsD, RtD, RdD, writeRegD};

   pipe_reg_ce_clr #(.W(CTRL_W + 1)) u_ctrlReg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (loadEn),
      .clr   (FlushE),
      .d     ({ValidD, ctrlLoad}),
      .q     ({ValidE, ctrlE})
   );

   pipe_reg_ce_clr #(.W(DATA_W)) u_dataReg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (loadEn),
      .clr   (FlushE),
      .d     (dataD),
      .q     (dataE)
   );

   assign {ImmE, RD1E, RD2E, PCPlus4E, RsE, RtE, RdE, WriteRegE} = dataE;

   assign RegWriteE   = ctrlE.regWrite;
   assign MemtoRegE   = ctrlE.memtoReg;
   assign MemWriteE   = ctrlE.memWrite;
   assign ALUSrcE     = ctrlE.aluSrc;
   assign RegDstE     = ctrlE.regDst;
   assign ALUControlE = ctrlE.aluControl;

   // A flushed edge is a bubble, never a stall.
   assign stallInc  = StallE && !FlushE;
   assign bubbleInc = FlushE || (!StallE && !ValidD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCntE  <= '0;
         BubbleCntE <= '0;
      end else begin
         if (stallInc && (StallCntE != '1))
            StallCntE <= StallCntE + CNTW'(1);
         if (bubbleInc && (BubbleCntE != '1))
            BubbleCntE <= BubbleCntE + CNTW'(1);
      end
   end

endmodule
